// File: rtl/vec_stage_skid_pkg.sv
// Shared types for the vector decode/execute stage register with skid buffer.
// Widths are fixed here; every file of the stage imports this package.
package vec_pipe_pkg;

  localparam int N      = 18;
  localparam int LANES  = 3;
  localparam int RA_W   = 4;
  localparam int ALUC_W = 4;

  typedef logic [LANES-1:0][N-1:0] lane_vec_t;

  typedef struct packed {
    logic              RegWrite;
    logic              MemtoReg;
    logic              MemWrite;
    logic              ALUSrc;
    logic [ALUC_W-1:0] ALUControl;
    logic [RA_W-1:0]   WA3;
  } exec_ctrl_t;

  typedef struct packed {
    lane_vec_t       rd1;
    lane_vec_t       rd2;
    lane_vec_t       extend;
    logic [RA_W-1:0] ra1;
    logic [RA_W-1:0] ra2;
    exec_ctrl_t      ctrl;
  } stage_payload_t;

  // Encoding is {main_valid, skid_valid}; 2'b01 never occurs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } skid_state_t;

endpackage

// File: rtl/vec_stage_skid_if.sv
// Valid/ready bundle bus carrying vector operands, addresses and exec control.
interface vec_stage_skid_if;
  import vec_pipe_pkg::*;

  logic              valid;
  logic              ready;
  lane_vec_t         rd1;
  lane_vec_t         rd2;
  lane_vec_t         extend;
  logic [RA_W-1:0]   ra1;
  logic [RA_W-1:0]   ra2;
  logic [RA_W-1:0]   WA3;
  logic              RegWrite;
  logic              MemtoReg;
  logic              MemWrite;
  logic              ALUSrc;
  logic [ALUC_W-1:0] ALUControl;

  modport master (
    output valid, rd1, rd2, extend, ra1, ra2, WA3,
           RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl,
    input  ready
  );

  modport slave (
    input  valid, rd1, rd2, extend, ra1, ra2, WA3,
           RegWrite, MemtoReg, MemWrite, ALUSrc, ALUControl,
    output ready
  );

endinterface

// File: rtl/vec_stage_skid_payload_reg.sv
// One stage_payload_t holding register with synchronous clear and load enable.
module stage_payload_reg
  import vec_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  stage_payload_t d,
  output stage_payload_t q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/vec_stage_skid.sv
// Decode/execute stage register with a two-entry skid buffer and flush.
//   state    | meaning
//   ST_EMPTY | nothing held
//   ST_ONE   | main entry holds the bundle being presented downstream
//   ST_FULL  | main presented, skid holds the next (younger) bundle
module vec_stage_skid
  import vec_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  vec_stage_skid_if.slave  up,
  vec_stage_skid_if.master dn,
  output logic [1:0]       occ
);

  skid_state_t    state, state_nxt;
  logic           in_ready, out_valid, accept, pop;
  logic           load_main, load_skid, main_from_skid;
  stage_payload_t in_pl, main_d, main_q, skid_q;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept)          state_nxt = ST_ONE;
        ST_ONE:   if (accept && !pop)  state_nxt = ST_FULL;
                  else if (!accept && pop) state_nxt = ST_EMPTY;
        ST_FULL:  if (pop)             state_nxt = ST_ONE;
        default:                       state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready looks only at registered state and flush, never at dn.ready.
  always_comb begin
    in_ready       = (state != ST_FULL) && !flush;
    out_valid      = (state != ST_EMPTY);
    accept         = up.valid && in_ready;
    pop            = out_valid && dn.ready;
    main_from_skid = (state == ST_FULL);
    load_main      = 1'b0;
    load_skid      = 1'b0;
    occ            = 2'd0;
    case (state)
      ST_EMPTY: load_main = accept;
      ST_ONE: begin
        load_main = accept && pop;
        load_skid = accept && !pop;
        occ       = 2'd1;
      end
      ST_FULL: begin
        load_main = pop && !flush;
        occ       = 2'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_pl                 = '0;
    in_pl.rd1             = up.rd1;
    in_pl.rd2             = up.rd2;
    in_pl.extend          = up.extend;
    in_pl.ra1             = up.ra1;
    in_pl.ra2             = up.ra2;
    in_pl.ctrl.WA3        = up.WA3;
    in_pl.ctrl.RegWrite   = up.RegWrite;
    in_pl.ctrl.MemtoReg   = up.MemtoReg;
    in_pl.ctrl.MemWrite   = up.MemWrite;
    in_pl.ctrl.ALUSrc     = up.ALUSrc;
    in_pl.ctrl.ALUControl = up.ALUControl;
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  stage_payload_reg u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  stage_payload_reg u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (in_pl),
    .q     (skid_q)
  );

  assign up.ready      = in_ready;
  assign dn.valid      = out_valid;
  assign dn.rd1        = main_q.rd1;
  assign dn.rd2        = main_q.rd2;
  assign dn.extend     = main_q.extend;
  assign dn.ra1        = main_q.ra1;
  assign dn.ra2        = main_q.ra2;
  assign dn.WA3        = main_q.ctrl.WA3;
  assign dn.MemtoReg   = main_q.ctrl.MemtoReg;
  assign dn.ALUSrc     = main_q.ctrl.ALUSrc;
  assign dn.ALUControl = main_q.ctrl.ALUControl;
  // Architectural write enables must never fire from a stale or flushed slot.
  assign dn.RegWrite   = main_q.ctrl.RegWrite & out_valid;
  assign dn.MemWrite   = main_q.ctrl.MemWrite & out_valid;

endmodule

// File: tb/tb_vec_stage_skid.sv
// Bench for vec_stage_skid: hand tables for backpressure/flush, queue model for random traffic.
module tb_vec_stage_skid;
  import vec_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] occ;

  vec_stage_skid_if up ();
  vec_stage_skid_if dn ();

  vec_stage_skid dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up),
    .dn    (dn),
    .occ   (occ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  stage_payload_t q[$];
  bit             last_v, last_ordy, last_fl;
  stage_payload_t last_p;

  typedef struct {
    bit v;
    int tag;
    bit ordy;
    bit fl;
    int e_occ;
    bit e_ov;
    bit e_ir;
    int e_tag;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic stage_payload_t mk(input int tag, input bit rnd);
    stage_payload_t p;
    p = '0;
    if (rnd) begin
      for (int l = 0; l < LANES; l++) begin
        p.rd1[l]    = N'($urandom);
        p.rd2[l]    = N'($urandom);
        p.extend[l] = N'($urandom);
      end
      p.ra1             = RA_W'($urandom);
      p.ra2             = RA_W'($urandom);
      p.ctrl.WA3        = RA_W'($urandom);
      p.ctrl.ALUControl = ALUC_W'($urandom);
      p.ctrl.RegWrite   = 1'($urandom);
      p.ctrl.MemtoReg   = 1'($urandom);
      p.ctrl.MemWrite   = 1'($urandom);
      p.ctrl.ALUSrc     = 1'($urandom);
    end else begin
      for (int l = 0; l < LANES; l++) begin
        p.rd1[l]    = N'(tag * (l * 7 + 1) + l);
        p.rd2[l]    = N'(tag + 100 + l);
        p.extend[l] = N'((tag << l) ^ 18'h2AAAA);
      end
      p.rd1[0]          = N'(tag);
      p.ra1             = RA_W'(tag);
      p.ra2             = RA_W'(~tag);
      p.ctrl.WA3        = RA_W'(tag + 1);
      p.ctrl.ALUControl = ALUC_W'(tag + 2);
      p.ctrl.MemtoReg   = 1'(tag);
      p.ctrl.ALUSrc     = 1'(tag >> 1);
      p.ctrl.RegWrite   = 1'b1;
      p.ctrl.MemWrite   = 1'b1;
    end
    return p;
  endfunction

  function automatic stage_payload_t get_out();
    stage_payload_t o;
    o.rd1             = dn.rd1;
    o.rd2             = dn.rd2;
    o.extend          = dn.extend;
    o.ra1             = dn.ra1;
    o.ra2             = dn.ra2;
    o.ctrl.WA3        = dn.WA3;
    o.ctrl.RegWrite   = dn.RegWrite;
    o.ctrl.MemtoReg   = dn.MemtoReg;
    o.ctrl.MemWrite   = dn.MemWrite;
    o.ctrl.ALUSrc     = dn.ALUSrc;
    o.ctrl.ALUControl = dn.ALUControl;
    return o;
  endfunction

  task automatic drive(input bit v, input stage_payload_t p, input bit ordy, input bit fl);
    up.valid      = v;
    up.rd1        = p.rd1;
    up.rd2        = p.rd2;
    up.extend     = p.extend;
    up.ra1        = p.ra1;
    up.ra2        = p.ra2;
    up.WA3        = p.ctrl.WA3;
    up.RegWrite   = p.ctrl.RegWrite;
    up.MemtoReg   = p.ctrl.MemtoReg;
    up.MemWrite   = p.ctrl.MemWrite;
    up.ALUSrc     = p.ctrl.ALUSrc;
    up.ALUControl = p.ctrl.ALUControl;
    dn.ready      = ordy;
    flush         = fl;
    last_v = v; last_p = p; last_ordy = ordy; last_fl = fl;
  endtask

  task automatic model_check();
    bit nonempty;
    nonempty = (q.size() > 0);
    chk("occ", 256'(occ), 256'(q.size()));
    chk("occ_le2", 256'(occ != 2'd3), 256'(1));
    chk("out_valid", 256'(dn.valid), 256'(nonempty));
    chk("in_ready", 256'(up.ready), 256'((q.size() < 2) && !flush));
    if (nonempty) chk("payload", 256'(get_out()), 256'(q[0]));
    chk("RegWriteO", 256'(dn.RegWrite), 256'(nonempty && q[0].ctrl.RegWrite));
    chk("MemWriteO", 256'(dn.MemWrite), 256'(nonempty && q[0].ctrl.MemWrite));
  endtask

  task automatic pre(input bit v, input stage_payload_t p, input bit ordy, input bit fl);
    drive(v, p, ordy, fl);
    #1;
    model_check();
  endtask

  // Reference: FIFO of depth 2; input accepted only when fewer than 2 held before the edge.
  task automatic post();
    int depth;
    @(posedge clk);
    depth = q.size();
    if (last_fl) begin
      q.delete();
    end else begin
      if (depth > 0 && last_ordy) void'(q.pop_front());
      if (last_v && depth < 2) q.push_back(last_p);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, mk(13, 1'b0), 1'b1, 1'b0);
    @(posedge clk);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("rst_occ", 256'(occ), 256'(0));
    chk("rst_out_valid", 256'(dn.valid), 256'(0));
    chk("rst_payload", 256'(get_out()), 256'(0));
    chk("rst_in_ready", 256'(up.ready), 256'(1));
  endtask

  vec_t tbl[$];
  stage_payload_t pt;
  lane_vec_t      exp_rd1;

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Pass-through of a hand-picked bundle
    pt = mk(0, 1'b0);
    exp_rd1[2] = 18'h3FFFF; exp_rd1[1] = 18'h00001; exp_rd1[0] = 18'h15555;
    pt.rd1 = exp_rd1;
    pt.ctrl.WA3 = 4'hA;
    pt.ctrl.RegWrite = 1'b1;
    pre(1'b1, pt, 1'b1, 1'b0);
    post();
    pre(1'b0, '0, 1'b1, 1'b0);
    chk("pt_rd1", 256'(dn.rd1), 256'(exp_rd1));
    chk("pt_wa3", 256'(dn.WA3), 256'(4'hA));
    chk("pt_regwrite", 256'(dn.RegWrite), 256'(1));
    chk("pt_occ", 256'(occ), 256'(1));
    chk("pt_valid", 256'(dn.valid), 256'(1));
    post();

    //          v  tag rdy fl occ ov ir otag
    tbl.push_back('{1, 1, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 2, 0, 0, 1, 1, 1, 1});
    tbl.push_back('{1, 3, 0, 0, 2, 1, 0, 1});
    tbl.push_back('{1, 3, 1, 0, 2, 1, 0, 1});
    tbl.push_back('{1, 3, 1, 0, 1, 1, 1, 2});
    tbl.push_back('{1, 4, 1, 0, 1, 1, 1, 3});
    tbl.push_back('{0, 0, 1, 0, 1, 1, 1, 4});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 5, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 6, 0, 0, 1, 1, 1, 5});
    tbl.push_back('{1, 8, 0, 1, 2, 1, 0, 5});
    tbl.push_back('{1, 9, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 10, 1, 1, 1, 1, 0, 9});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 1, 0});
    foreach (tbl[i]) begin
      pre(tbl[i].v, mk(tbl[i].tag, 1'b0), tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl%0d_occ", i), 256'(occ), 256'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_ov", i), 256'(dn.valid), 256'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_ir", i), 256'(up.ready), 256'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_we", i), 256'({dn.RegWrite, dn.MemWrite}), 256'({tbl[i].e_ov, tbl[i].e_ov}));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_tag", i), 256'(dn.rd1[0]), 256'(N'(tbl[i].e_tag)));
      post();
    end

    // Reset while FULL, then restart with tag 7
    pre(1'b1, mk(11, 1'b0), 1'b0, 1'b0); post();
    pre(1'b1, mk(12, 1'b0), 1'b0, 1'b0); post();
    pre(1'b0, '0, 1'b0, 1'b0);
    chk("full_occ", 256'(occ), 256'(2));
    do_reset();
    model_check();
    pre(1'b1, mk(7, 1'b0), 1'b1, 1'b0); post();
    pre(1'b0, '0, 1'b1, 1'b0);
    chk("restart_tag", 256'(dn.rd1[0]), 256'(N'(7)));
    post();

    // Random traffic against the queue model
    for (int i = 0; i < 1000; i++) begin
      pre($urandom_range(0, 3) != 0, mk(i, 1'b1), $urandom_range(0, 3) != 0,
          $urandom_range(0, 31) == 0);
      post();
    end
    pre(1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
